// File: rtl/demux_1x16_frame.sv
// Serial-to-parallel frame demux: steers one bit per transfer into a slot of a 16-bit word
// and offers the completed word downstream with a valid/ready handshake.
// Optional parity port set enabled by defining DEMUX_FRAME_PARITY_EN.
module demux_1x16_frame #(
  parameter int N_OUT = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inp_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [SEL_W-1:0] sel,
  input  logic             auto_i,
  input  logic             flush_i,
  output logic [N_OUT-1:0] out_o,
  output logic [SEL_W:0]   count_o,
  output logic             frame_valid_o,
  input  logic             frame_ready_i
`ifdef DEMUX_FRAME_PARITY_EN
  ,
  input  logic             parity_i,
  output logic             parity_o,
  output logic             parity_err_o
`endif
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state;
  logic [N_OUT-1:0] mask;
  logic [SEL_W-1:0] cnt;

  logic [SEL_W-1:0] idx;
  logic             accept;
  logic             new_slot;
  logic             full_nxt;
  logic [N_OUT-1:0] out_nxt;
  logic [N_OUT-1:0] mask_nxt;

  always_comb begin
    idx      = auto_i ? cnt : sel;
    accept   = in_valid_i & in_ready_o;
    out_nxt  = out_o;
    mask_nxt = mask;
    if (accept) begin
      out_nxt[idx]  = inp_i;
      mask_nxt[idx] = 1'b1;
    end
    // Only first writes to a slot advance the count; rewrites just overwrite the bit.
    new_slot = accept & ~mask[idx];
    full_nxt = &mask_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= FILL;
      out_o         <= '0;
      mask          <= '0;
      cnt           <= '0;
      count_o       <= '0;
      frame_valid_o <= 1'b0;
      in_ready_o    <= 1'b1;
`ifdef DEMUX_FRAME_PARITY_EN
      parity_o      <= 1'b0;
      parity_err_o  <= 1'b0;
`endif
    end else if (flush_i) begin
      state         <= FILL;
      out_o         <= '0;
      mask          <= '0;
      cnt           <= '0;
      count_o       <= '0;
      frame_valid_o <= 1'b0;
      in_ready_o    <= 1'b1;
`ifdef DEMUX_FRAME_PARITY_EN
      parity_o      <= 1'b0;
      parity_err_o  <= 1'b0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            out_o   <= out_nxt;
            mask    <= mask_nxt;
            count_o <= count_o + (SEL_W+1)'(new_slot);
            if (auto_i) cnt <= cnt + SEL_W'(1);
`ifdef DEMUX_FRAME_PARITY_EN
            parity_o <= ^out_nxt;
`endif
            if (full_nxt) begin
              state         <= HOLD;
              in_ready_o    <= 1'b0;
              frame_valid_o <= 1'b1;
`ifdef DEMUX_FRAME_PARITY_EN
              parity_err_o  <= parity_i ^ (^out_nxt);
`endif
            end
          end
        end
        HOLD: begin
          // out_o is deliberately kept; the next frame overwrites it slot by slot.
          if (frame_ready_i) begin
            state         <= FILL;
            mask          <= '0;
            cnt           <= '0;
            count_o       <= '0;
            in_ready_o    <= 1'b1;
            frame_valid_o <= 1'b0;
`ifdef DEMUX_FRAME_PARITY_EN
            parity_err_o  <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_1x16_frame.sv
// Scoreboard bench for demux_1x16_frame: directed scenarios plus randomized frames
// checked against a bit-array reference model.
module tb_demux_1x16_frame;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        inp_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  sel;
  logic        auto_i;
  logic        flush_i;
  logic [15:0] out_o;
  logic [4:0]  count_o;
  logic        frame_valid_o;
  logic        frame_ready_i;
`ifdef DEMUX_FRAME_PARITY_EN
  logic        parity_i;
  logic        parity_o;
  logic        parity_err_o;
`endif

  demux_1x16_frame #(.N_OUT(16), .SEL_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .inp_i(inp_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .sel(sel), .auto_i(auto_i), .flush_i(flush_i),
    .out_o(out_o), .count_o(count_o), .frame_valid_o(frame_valid_o),
    .frame_ready_i(frame_ready_i)
`ifdef DEMUX_FRAME_PARITY_EN
    , .parity_i(parity_i), .parity_o(parity_o), .parity_err_o(parity_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: the word, which slots were written, the auto pointer, parity error flag.
  bit [15:0] m_word;
  bit [15:0] m_mask;
  int        m_cnt;
  bit        m_perr;
  bit [15:0] exp_q[$];
  bit        fv_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear(input bit clr_word);
    m_mask = '0;
    m_cnt  = 0;
    m_perr = 1'b0;
    if (clr_word) m_word = '0;
  endfunction

  task automatic step(input bit v, input bit a, input bit [3:0] s, input bit b,
                      input bit fr, input bit fl, input bit par);
    int idx;
    in_valid_i = v; auto_i = a; sel = s; inp_i = b;
    frame_ready_i = fr; flush_i = fl;
`ifdef DEMUX_FRAME_PARITY_EN
    parity_i = par;
`endif
    @(posedge clk_i);
    if (fl) model_clear(1'b1);
    else if (m_mask == 16'hFFFF) begin
      if (fr) model_clear(1'b0);
    end else if (v) begin
      idx = a ? m_cnt : int'(s);
      m_word[idx] = b;
      m_mask[idx] = 1'b1;
      if (a) m_cnt = (m_cnt + 1) % 16;
      if (m_mask == 16'hFFFF) begin
        m_perr = (par != ^m_word);
        exp_q.push_back(m_word);
      end
    end
    #1;
    in_valid_i = 1'b0; frame_ready_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic send_auto_word(input bit [15:0] w, input bit par);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 4'd0, w[i], 1'b0, 1'b0, par);
  endtask

  task automatic release_frame();
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: status outputs every cycle, completed frames popped from the scoreboard.
  initial begin
    fv_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      chk("count", count_o, $countones(m_mask));
      chk("in_ready", in_ready_o, m_mask != 16'hFFFF);
      chk("frame_valid", frame_valid_o, m_mask == 16'hFFFF);
      chk("out_word", out_o, m_word);
`ifdef DEMUX_FRAME_PARITY_EN
      chk("parity", parity_o, ^m_word);
      chk("parity_err", parity_err_o, m_perr);
`endif
      if (frame_valid_o && !fv_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_unexpected: got %0h expected no frame", out_o);
        end else begin
          chk("frame_word", out_o, exp_q.pop_front());
        end
      end
      fv_prev = frame_valid_o;
    end
  end

  initial begin
    bit [15:0] w;
    int guard;
    rst_i = 1'b1; inp_i = 1'b0; in_valid_i = 1'b0; auto_i = 1'b0; sel = '0;
    flush_i = 1'b0; frame_ready_i = 1'b0;
`ifdef DEMUX_FRAME_PARITY_EN
    parity_i = 1'b0;
`endif
    model_clear(1'b1);
    #1;
    chk("rst_out", out_o, 16'h0);
    chk("rst_ready", in_ready_o, 1'b1);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Auto mode, LSB first; valid rises one clock after the 16th accept.
    w = 16'hABAB;
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 4'd0, w[i], 1'b0, 1'b0, 1'b0);
    chk("abab_fv_early", frame_valid_o, 1'b0);
    step(1'b1, 1'b1, 4'd0, w[15], 1'b0, 1'b0, 1'b0);
    chk("abab_fv", frame_valid_o, 1'b1);
    chk("abab_out", out_o, 16'hABAB);
    chk("abab_count", count_o, 5'd16);
    chk("abab_ready", in_ready_o, 1'b0);
    release_frame();

    // Explicit select, slots 15..0, with a duplicate write of 0 to slot 6.
    w = 16'h1240;
    for (int i = 15; i >= 6; i--) step(1'b1, 1'b0, 4'(i), w[i], 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dup_count", count_o, 5'd10);
    for (int i = 5; i >= 0; i--) step(1'b1, 1'b0, 4'(i), w[i], 1'b0, 1'b0, 1'b0);
    chk("sel_out", out_o, 16'h1200);
    chk("sel_count", count_o, 5'd16);
    release_frame();

    // Backpressure with in_valid held high during HOLD.
    send_auto_word(16'hFFF4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'($urandom), 1'b0, 1'b0, 1'b0);
      chk("bp_out", out_o, 16'hFFF4);
      chk("bp_ready", in_ready_o, 1'b0);
    end
    release_frame();
    chk("bp_rel_count", count_o, 5'd0);
    chk("bp_rel_ready", in_ready_o, 1'b1);

    // Flush after seven auto writes; next auto write lands in slot 0.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("flush_out", out_o, 16'h0);
    chk("flush_count", count_o, 5'd0);
    step(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("flush_slot0", out_o, 16'h0001);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle while holding a frame.
    send_auto_word(16'h5A3C, 1'b0);
    #2 rst_i = 1'b1;
    model_clear(1'b1);
    exp_q.delete();
    #1;
    chk("arst_out", out_o, 16'h0);
    chk("arst_count", count_o, 5'd0);
    chk("arst_fv", frame_valid_o, 1'b0);
    chk("arst_ready", in_ready_o, 1'b1);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    send_auto_word(16'h8240, 1'b0);
    chk("post_rst_out", out_o, 16'h8240);
    chk("post_rst_fv", frame_valid_o, 1'b1);
    release_frame();

`ifdef DEMUX_FRAME_PARITY_EN
    send_auto_word(16'hABCD, 1'b0);
    chk("par0_parity", parity_o, 1'b0);
    chk("par0_err", parity_err_o, 1'b0);
    release_frame();
    send_auto_word(16'hABCD, 1'b1);
    chk("par1_err", parity_err_o, 1'b1);
    release_frame();
    chk("par1_err_clr", parity_err_o, 1'b0);
`endif

    // Randomized frames: mixed auto/explicit, idles, rare flushes, backpressure.
    for (int f = 0; f < 20; f++) begin
      guard = 0;
      while (m_mask != 16'hFFFF && guard < 400) begin
        step($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0, 63) == 0, 1'($urandom));
        guard++;
      end
      if (guard >= 400) chk("rand_frame_timeout", guard, 0);
      repeat ($urandom_range(0, 3))
        step(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'b0, 1'($urandom));
      step(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'b0, 1'($urandom));
    end

    @(negedge clk_i);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
